// File: rtl/bfly_stage_ctrl.sv
// Radix-2 SDF butterfly stage sequencer: fill/drain vs butterfly
// half, twiddle addressing, output select and backpressure.
module bfly_stage_ctrl #(
  parameter int FRAME_BEATS = 1024,
  parameter int TW_GROUPS   = 4,
  parameter int CNT_W       = $clog2(FRAME_BEATS),
  parameter int TW_AW       = $clog2(TW_GROUPS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_sel,
  output logic             sr_shift,
  output logic             sr_sel,
  output logic             bfly_en,
  output logic [TW_AW-1:0] tw_addr,
  output logic             frame_done,
  output logic             busy
);

  localparam int HALF = FRAME_BEATS / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BEATS - 1);
  localparam logic [CNT_W-1:0] HLAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             done_q, done_d;
  logic             ph;
  logic             acc;
  logic             fl_go;

  assign ph = cnt_q[CNT_W-1];
  // ph-0 beats without a pending drain emit nothing, so skip out_ready
  assign in_ready = (state_q != FLUSH) &
                    (out_ready | (~ph & ~drain_q));
  assign acc = in_valid & in_ready;
  assign fl_go = (state_q == RUN) & (cnt_q == '0) & drain_q &
                 flush_req & ~in_valid;
  assign tw_addr = ph ? cnt_q[CNT_W-2 -: TW_AW] : '0;
  assign frame_done = done_q;
  assign busy = (state_q != IDLE) | drain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    sr_shift  = 1'b0;
    sr_sel    = 1'b0;
    bfly_en   = 1'b0;
    out_valid = 1'b0;
    out_sel   = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (acc) begin
          sr_shift  = 1'b1;
          sr_sel    = ph;
          bfly_en   = ph;
          out_valid = ph | drain_q;
          out_sel   = ~ph;
          cnt_d     = cnt_q + ONE;
          state_d   = RUN;
          if (cnt_q == LAST) begin
            drain_d = 1'b1;
            done_d  = 1'b1;
          end
          if (cnt_q == HLAST && drain_q)
            drain_d = 1'b0;
        end else if (fl_go) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_ready) begin
          sr_shift  = 1'b1;
          out_valid = 1'b1;
          out_sel   = 1'b1;
          cnt_d     = cnt_q + ONE;
          if (cnt_q == HLAST) begin
            cnt_d   = '0;
            drain_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        drain_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Directed bench for bfly_stage_ctrl: small 16-beat frame instance
// plus a default-size instance for twiddle stepping.
module tb_bfly_stage_ctrl;

  logic       clk;
  logic       rstn;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic       flush_req;
  logic       out_ready;
  logic       out_valid;
  logic       out_sel;
  logic       sr_shift;
  logic       sr_sel;
  logic       bfly_en;
  logic [1:0] tw_addr;
  logic       frame_done;
  logic       busy;

  logic       b_iv;
  logic       b_ir;
  logic       b_or;
  logic       b_ov;
  logic       b_os;
  logic       b_sh;
  logic       b_ss;
  logic       b_be;
  logic [1:0] b_tw;
  logic       b_fd;
  logic       b_busy;

  int checks;
  int failures;

  bfly_stage_ctrl #(.FRAME_BEATS(16), .TW_GROUPS(4)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .flush_req(flush_req), .out_ready(out_ready),
    .out_valid(out_valid), .out_sel(out_sel),
    .sr_shift(sr_shift), .sr_sel(sr_sel),
    .bfly_en(bfly_en), .tw_addr(tw_addr),
    .frame_done(frame_done), .busy(busy)
  );

  bfly_stage_ctrl dut_big (
    .clk(clk), .rstn(rstn), .clr(1'b0),
    .in_valid(b_iv), .in_ready(b_ir),
    .flush_req(1'b0), .out_ready(b_or),
    .out_valid(b_ov), .out_sel(b_os),
    .sr_shift(b_sh), .sr_sel(b_ss),
    .bfly_en(b_be), .tw_addr(b_tw),
    .frame_done(b_fd), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fr;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[42];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {in_ready, sr_shift, sr_sel, out_valid, out_sel,
            bfly_en, tw_addr, frame_done, busy};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b;
    logic       ph;
    logic [1:0] tw;
    int         ovn;
    checks = 0;
    failures = 0;

    for (int i = 0; i < 32; i++) begin
      b  = 4'(i % 16);
      ph = b[3];
      tw = ph ? 2'((b - 8) / 2) : 2'd0;
      tbl[i].iv   = 1'b1;
      tbl[i].ordy = 1'b1;
      tbl[i].fr   = (i == 16);
      tbl[i].exp  = {1'b1, 1'b1, ph, ph | (i >= 16), !ph,
                     ph, tw, 1'(i == 16), 1'(i != 0)};
    end
    tbl[32] = '{1'b0, 1'b1, 1'b1, 10'b1000000011};
    for (int i = 33; i < 41; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b1, 10'b0101100001};
    tbl[41] = '{1'b0, 1'b1, 1'b0, 10'b1000000000};

    rstn = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    flush_req = 1'b0;
    out_ready = 1'b1;
    b_iv = 1'b0;
    b_or = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h200);
    nxt();

    ovn = 0;
    for (int i = 0; i < 42; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      flush_req = tbl[i].fr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      if (i < 32 && out_valid && out_ready) ovn++;
      nxt();
    end
    chk("out_beats_pre_flush", 32'(ovn), 32'd24);
    flush_req = 1'b0;

    clr = 1'b1;
    nxt();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    nxt();

    // stall at butterfly beat 10
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stall_pre%0d", k), 32'(sr_shift), 32'd1);
      nxt();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_rdy%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("stall_sh%0d", k), 32'(sr_shift), 32'd0);
      chk($sformatf("stall_tw%0d", k), 32'(tw_addr), 32'd1);
      chk($sformatf("stall_ov%0d", k), 32'(out_valid), 32'd0);
      nxt();
    end
    out_ready = 1'b1;
    for (int k = 10; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("resume_tw%0d", k), 32'(tw_addr),
          32'((k - 8) / 2));
      chk($sformatf("resume_sh%0d", k), 32'(sr_shift), 32'd1);
      chk($sformatf("resume_fd%0d", k), 32'(frame_done), 32'd0);
      nxt();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_frame_done", 32'(frame_done), 32'd1);
    nxt();

    // reset during frame 2
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("f2_drain%0d", k), 32'({out_valid, out_sel}),
          32'd3);
      nxt();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 32'(outs()), 32'h200);
    nxt();
    rstn = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", k),
          32'({out_valid, sr_shift, sr_sel, bfly_en}), 32'b0100);
      nxt();
    end
    in_valid = 1'b0;

    // default-size instance: 1024-beat frame
    b_iv = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (k == 511 || k == 512 || k == 639 || k == 640 ||
          k == 767 || k == 768 || k == 895 || k == 896 ||
          k == 1023)
        chk($sformatf("big_tw%0d", k), 32'(b_tw),
            (k < 512) ? 32'd0 : 32'((k - 512) / 128));
      if (k == 1023)
        chk("big_fd_early", 32'(b_fd), 32'd0);
      nxt();
    end
    b_iv = 1'b0;
    @(negedge clk);
    chk("big_frame_done", 32'(b_fd), 32'd1);
    nxt();
    @(negedge clk);
    chk("big_fd_pulse", 32'(b_fd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
